// File: rtl/tube_collision_score_if.sv
// Bus between the tube/bird front end and the collision/score block.
// The master side supplies per-frame geometry and player input; the slave
// side returns game state, score and the restart pulse for the tube generator.
interface tube_collision_score_if;
  logic        frame_tick;
  logic        flap;
  logic [10:0] bird_y;
  logic [10:0] tube_x [2:0];
  logic [10:0] gap_y  [2:0];
  logic        running;
  logic        dead;
  logic        hit;
  logic [9:0]  score;
  logic [9:0]  best;
  logic        tube_game_rst;

  modport master (
    output frame_tick, flap, bird_y, tube_x, gap_y,
    input  running, dead, hit, score, best, tube_game_rst
  );

  modport slave (
    input  frame_tick, flap, bird_y, tube_x, gap_y,
    output running, dead, hit, score, best, tube_game_rst
  );
endinterface

// File: rtl/tube_collision_score.sv
// Collision detection, scoring and READY/RUN/DEAD game control.
// Each accepted frame_tick snapshots the geometry, then one shared tube
// comparator walks tubes 0..2 on consecutive cycles and the accumulated
// verdict is committed on the fourth cycle after the tick.
module tube_collision_score #(
  parameter int SCREEN_HEIGHT = 768,
  parameter int TUBE_WIDTH    = 120,
  parameter int GAP_HEIGHT    = 250,
  parameter int BIRD_X        = 200,
  parameter int BIRD_SIZE     = 40,
  parameter int SCORE_MAX     = 999
) (
  input  logic                    clk,
  input  logic                    rst,
  tube_collision_score_if.slave   bus
);

  typedef enum logic [1:0] {G_READY, G_RUN, G_DEAD} game_e;
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_COMMIT} scan_e;

  // Geometry constants widened to 12 bits so sums and differences never wrap.
  localparam logic signed [11:0] TW_S   = 12'(TUBE_WIDTH);
  localparam logic signed [11:0] BX_S   = 12'(BIRD_X);
  localparam logic signed [11:0] BXR_S  = 12'(BIRD_X + BIRD_SIZE);
  localparam logic        [11:0] BS_U   = 12'(BIRD_SIZE);
  localparam logic        [11:0] GH_U   = 12'(GAP_HEIGHT);
  localparam logic        [11:0] SH_U   = 12'(SCREEN_HEIGHT);
  localparam logic        [10:0] SMAX11 = 11'(SCORE_MAX);
  localparam logic        [9:0]  SMAX10 = 10'(SCORE_MAX);

  game_e game_q, game_d;
  scan_e scan_q, scan_d;

  logic [10:0] snap_by;
  logic [10:0] snap_tx [2:0];
  logic [10:0] snap_gy [2:0];

  logic       hit_acc;
  logic [2:0] pass_acc;
  logic [2:0] clr_acc;
  logic [2:0] passed;
  logic [9:0] score_q;
  logic [9:0] best_q;
  logic       hit_q;
  logic       tgr_q;

  logic scan_start;
  logic scan_eval;
  assign scan_start = (game_q == G_RUN) && (scan_q == S_IDLE) && bus.frame_tick;
  assign scan_eval  = (scan_q == S_T0) || (scan_q == S_T1) || (scan_q == S_T2);

  // Select the snapshot of the tube under test this cycle.
  logic [2:0]  tube_sel;
  logic [10:0] cur_tx;
  logic [10:0] cur_gy;
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    tube_sel = 3'b000;
    cur_tx   = snap_tx[0];
    cur_gy   = snap_gy[0];
    case (scan_q)
      S_T0: begin tube_sel = 3'b001; cur_tx = snap_tx[0]; cur_gy = snap_gy[0]; end
      S_T1: begin tube_sel = 3'b010; cur_tx = snap_tx[1]; cur_gy = snap_gy[1]; end
      S_T2: begin tube_sel = 3'b100; cur_tx = snap_tx[2]; cur_gy = snap_gy[2]; end
      default: ;
    endcase
  end

  // Shared per-tube collision/pass test plus ground test and score update.
  logic signed [11:0] tx_s;
  logic signed [11:0] left_s;
  logic [11:0] by_u, bird_bot, gap_top, gap_end;
  logic        x_overlap, y_bad, cur_collide, cur_pass, cur_clear;
  logic        ground, collide;
  logic [1:0]  pass_cnt;
  logic [10:0] score_sum;
  logic [9:0]  score_run;
  always_comb begin
    tx_s        = signed'({1'b0, cur_tx});
    left_s      = tx_s - TW_S;
    by_u        = {1'b0, snap_by};
    bird_bot    = by_u + BS_U;
    gap_top     = {1'b0, cur_gy};
    gap_end     = gap_top + GH_U;
    x_overlap   = (tx_s > BX_S) && (left_s < BXR_S);
    y_bad       = (by_u < gap_top) || (bird_bot > gap_end);
    cur_collide = x_overlap && y_bad;
    cur_pass    = (tx_s <= BX_S) && ((passed & tube_sel) == 3'b000);
    cur_clear   = tx_s > BXR_S;
    ground      = bird_bot > SH_U;
    collide     = hit_acc || ground;
    pass_cnt    = {1'b0, pass_acc[0]} + {1'b0, pass_acc[1]} + {1'b0, pass_acc[2]};
    score_sum   = {1'b0, score_q} + {9'd0, pass_cnt};
    score_run   = (score_sum > SMAX11) ? SMAX10 : score_sum[9:0];
  end

  // Game and scan state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      game_q <= G_READY;
      scan_q <= S_IDLE;
    end else begin
      game_q <= game_d;
      scan_q <= scan_d;
    end
  end

  // Next-state logic: READY waits for flap, RUN sequences the scan, DEAD waits for flap.
  always_comb begin
    game_d = game_q;
    scan_d = S_IDLE;
    case (game_q)
      G_READY: if (bus.flap) game_d = G_RUN;
      G_RUN: begin
        case (scan_q)
          S_IDLE:   scan_d = bus.frame_tick ? S_T0 : S_IDLE;
          S_T0:     scan_d = S_T1;
          S_T1:     scan_d = S_T2;
          S_T2:     scan_d = S_COMMIT;
          S_COMMIT: begin
            scan_d = S_IDLE;
            if (collide) game_d = G_DEAD;
          end
          default:  scan_d = S_IDLE;
        endcase
      end
      G_DEAD: if (bus.flap) game_d = G_READY;
      default: game_d = G_READY;
    endcase
  end

  // Geometry snapshot taken when a scan starts.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; the snapshot is only read during a scan, which
    // always begins by loading it.
    if (scan_start) begin
      snap_by <= bus.bird_y;
      for (int i = 0; i < 3; i++) begin
        snap_tx[i] <= bus.tube_x[i];
        snap_gy[i] <= bus.gap_y[i];
      end
    end
  end

  // Accumulators, pass flags, scores and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_acc  <= 1'b0;
      pass_acc <= 3'b000;
      clr_acc  <= 3'b000;
      passed   <= 3'b000;
      score_q  <= 10'd0;
      best_q   <= 10'd0;
      hit_q    <= 1'b0;
      tgr_q    <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      tgr_q <= 1'b0;
      if (scan_start) begin
        hit_acc  <= 1'b0;
        pass_acc <= 3'b000;
        clr_acc  <= 3'b000;
      end
      if (scan_eval) begin
        hit_acc <= hit_acc | cur_collide;
        if (cur_pass)  pass_acc <= pass_acc | tube_sel;
        if (cur_clear) clr_acc  <= clr_acc  | tube_sel;
      end
      if (scan_q == S_COMMIT) begin
        passed <= (passed | pass_acc) & ~clr_acc;
        if (collide) begin
          // Collision wins over any pass in the same frame.
          hit_q <= 1'b1;
          if (score_q > best_q) best_q <= score_q;
        end else begin
          score_q <= score_run;
        end
      end
      if ((game_q == G_READY) && bus.flap) passed <= 3'b000;
      if ((game_q == G_DEAD) && bus.flap) begin
        tgr_q   <= 1'b1;
        score_q <= 10'd0;
        passed  <= 3'b000;
      end
    end
  end

  assign bus.running       = (game_q == G_RUN);
  assign bus.dead          = (game_q == G_DEAD);
  assign bus.hit           = hit_q;
  assign bus.score         = score_q;
  assign bus.best          = best_q;
  assign bus.tube_game_rst = tgr_q;

endmodule

// File: doc/tube_collision_score.md
Name: tube_collision_score

Overview:
- Consumes the three tube positions (right edge x, gap top y) from the tube generator, plus the bird's vertical position.
- Once per frame it scans the tubes sequentially for collisions and pass events.
- Runs the game state machine (READY/RUN/DEAD), keeps the current and best score, and issues the game-restart pulse back to the tube generator.

Parameters:
- SCREEN_HEIGHT, 768: playfield height in px; bird bottom beyond it = ground hit.
- TUBE_WIDTH, 120: tube width; tube i spans x = tube_x[i]-TUBE_WIDTH .. tube_x[i]-1.
- GAP_HEIGHT, 250: gap spans y = gap_y[i] .. gap_y[i]+GAP_HEIGHT-1.
- BIRD_X, 200: fixed left x of bird box.
- BIRD_SIZE, 40: bird box edge length (square).
- SCORE_MAX, 999: score saturation value.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame; starts a scan
- flap  in  1  one-cycle pulse from player input
- bird_y  in  11  bird box top y
- tube_x  in  11 x3 (unpacked [2:0])  tube right-edge x
- gap_y  in  11 x3 (unpacked [2:0])  gap top y
- running  out  1  high in RUN
- dead  out  1  high in DEAD
- hit  out  1  one-cycle pulse on collision
- score  out  10  current score, unsigned binary
- best  out  10  best score since rst
- tube_game_rst  out  1  one-cycle pulse to tube generator game_rst

Behaviour:
- Reset (async, rst=1):
  - state=READY; scan idle.
  - running=0, dead=0, hit=0, tube_game_rst=0.
  - score=0, best=0, passed[2:0]=0.
- READY:
  - On flap: go to RUN; passed[2:0]=0; score stays 0.
  - frame_tick is ignored.
- RUN scan:
  - Edge E samples frame_tick=1 with scan idle: snapshot bird_y, tube_x[], gap_y[] into internal regs.
  - Edges E+1, E+2, E+3 evaluate tubes 0, 1, 2 from the snapshot, accumulating hit_acc and pass_acc.
  - Edge E+4 commits the results.
  - frame_tick arriving while a scan is in progress is ignored (not queued).
- Per-tube test:
  - x_overlap = (tube_x > BIRD_X) && (tube_x - TUBE_WIDTH < BIRD_X + BIRD_SIZE). Compute as 12-bit signed so tube_x < TUBE_WIDTH is correct.
  - y_bad = (bird_y < gap_y) || (bird_y + BIRD_SIZE > gap_y + GAP_HEIGHT). Use 12-bit sums; no wrap.
  - Collision = x_overlap && y_bad.
  - Pass = (tube_x <= BIRD_X) && !passed[i]. A pass sets passed[i] at commit.
  - passed[i] clears at commit when tube_x > BIRD_X + BIRD_SIZE (tube respawned to the right).
- Ground/ceiling collision, evaluated on the snapshot: bird_y + BIRD_SIZE > SCREEN_HEIGHT. bird_y is unsigned, so there is no ceiling underflow case.
- Commit at E+4:
  - If any collision: hit=1 for one cycle; state=DEAD; best=max(best, score). Score is NOT incremented this frame, even if a pass occurred too (collision has priority).
  - Else: score += number of passes, saturating at SCORE_MAX.
- DEAD:
  - frame_tick is ignored.
  - On flap: tube_game_rst=1 for one cycle, score=0, passed=0, state=READY.
- flap while in RUN: ignored by this block (bird physics is elsewhere).
- Outputs are registered: running and dead decode the state register.
- Async rst mid-scan: the scan is aborted and all outputs take their reset values immediately.

Test Plan:
- Assert rst for 3 cycles mid-RUN -> running=0, dead=0, score=0, best=0, hit=0 immediately; no tube_game_rst.
- READY, flap, then frame_tick with tube_x[0]=300, gap_y[0]=300, bird_y=400 (others at 1100) -> no hit; score 0; running=1.
- Same stimulus but bird_y=290 -> hit pulse exactly 4 cycles after frame_tick edge; dead=1, running=0; best=0.
- RUN, tube_x[0]=199, bird_y in gap -> score=1. Five more frames with tube_x[0]=199 -> score stays 1. tube_x[0]=1144, then 199 -> score=2.
- RUN, bird_y=729 with no tube overlap -> ground hit (769>768); bird_y=728 -> no hit.
- Preload score=999 via passes; pass again -> score stays 999. Collision -> best=999. Flap in DEAD -> tube_game_rst one-cycle pulse, score=0, state READY, best=999.
